multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle FSM controller for the 8-bit, 4-register CPU datapath.
- Sequences the shared memory port (instruction and data), IR, PC, register file, ALU and the 2-bit-to-8-bit immediate sign-extend path. Each instruction takes 4–5 states.
- Instruction format: op[7:6], rs[5:4], rt[3:2], imm/rd[1:0].
- Opcodes: 00 = ADD (rd <- rs + rt), 01 = LW (rt <- M[rs + sext(imm)]), 10 = SW (M[rs + sext(imm)] <- rt), 11 = BEQ (if rs == rt then pc <- pc + sext(imm)).

Parameters:
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- op  input  2  opcode from IR[7:6].
- zero  input  1  ALU zero flag; valid in EXEC.
- mem_ready  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_read  output  1  read access.
- mem_write  output  1  write access.
- iord  output  1  address mux: 0 = PC, 1 = ALU result register.
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  load PC.
- pc_src  output  1  PC mux: 0 = PC+1, 1 = branch target (PC + sext imm).
- alu_src_imm  output  1  ALU B operand: 0 = rt data, 1 = sign-extended imm.
- alu_op  output  2  00 = add, 01 = sub; other codes unused.
- reg_write  output  1  register file write enable.
- reg_dst  output  1  write address: 0 = rt, 1 = rd (instr[1:0]).
- mem_to_reg  output  1  write data: 0 = ALU result, 1 = memory data.
- retire  output  1  one-cycle pulse per completed instruction.
- retired_cnt  output  CNT_W  completed-instruction count.
- state_dbg  output  3  current state encoding.

Behaviour:
- State encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB_R = 5, WB_M = 6.
- Reset:
  - Asynchronous: state <- IDLE, retired_cnt <- 0.
  - All control outputs are combinational decodes of state/op/mem_ready/zero, so all are 0 in IDLE.
- IDLE: all outputs 0; next state FETCH unconditionally.
- FETCH:
  - mem_req = 1, mem_read = 1, iord = 0.
  - Hold while mem_ready = 0.
  - On the mem_ready cycle: ir_write = 1, pc_write = 1, pc_src = 0; next state DECODE.
- DECODE: all outputs 0; register file reads rs/rt; next state EXEC.
- EXEC by op:
  - 00: alu_src_imm = 0, alu_op = 00; next state WB_R.
  - 01/10: alu_src_imm = 1, alu_op = 00 (address calculation); next state MEM.
  - 11: alu_src_imm = 0, alu_op = 01.
    - If zero = 1: pc_write = 1, pc_src = 1.
    - retire = 1; next state FETCH.
- MEM:
  - mem_req = 1, iord = 1.
  - mem_read = 1 when op = 01; mem_write = 1 when op = 10.
  - Hold while mem_ready = 0.
  - On mem_ready: op 01 -> WB_M; op 10 -> retire = 1, next state FETCH.
- WB_R: reg_write = 1, reg_dst = 1, mem_to_reg = 0, retire = 1; next state FETCH.
- WB_M: reg_write = 1, reg_dst = 0, mem_to_reg = 1, retire = 1; next state FETCH.
- Invariants:
  - mem_read and mem_write are never both 1.
  - mem_read/mem_write are 0 whenever mem_req = 0.
  - op is sampled only in EXEC and MEM; the IR holds it stable after FETCH.
- retired_cnt increments by 1 on each clock edge where retire = 1, wrapping from 2^CNT_W−1 to 0.
- Latency at zero memory wait:
  - ADD = 4 cycles; BEQ = 3 cycles (FETCH, DECODE, EXEC).
  - SW = 4 cycles; LW = 5 cycles.
  - Each wait cycle adds 1.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-access: the access is abandoned immediately, mem_req drops asynchronously, and no write-back occurs.
- Illegal state encodings (7) go to IDLE on the next edge.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - FETCH is entered from IDLE only on a cycle where step = 1.
  - Every retiring transition goes to IDLE instead of FETCH, so the core executes exactly one instruction per step pulse.
  - A step held high runs continuously, with one IDLE cycle between instructions.
- Undefined: no step port; flow is as described above.

Test Plan:
- Reset release, mem_ready = 1 constantly -> IDLE for 1 cycle, then FETCH with mem_req = 1, ir_write = 1, pc_write = 1, pc_src = 0; retired_cnt = 0.
- ADD (op = 00), zero memory wait -> states 1, 2, 3, 5; reg_write = 1 with reg_dst = 1 in WB_R; retire pulses once; retired_cnt = 1.
- LW (op = 01), mem_ready low for 3 cycles in MEM -> MEM held 4 cycles with iord = 1, mem_read = 1; then WB_M with mem_to_reg = 1, reg_dst = 0; total 8 cycles.
- BEQ with zero = 1, then BEQ with zero = 0 -> first: pc_write = 1, pc_src = 1 in EXEC; second: pc_write = 0 in EXEC; both retire in 3 cycles.
- SW stalled in MEM, reset asserted for 1 cycle -> mem_req and mem_write drop in the same cycle; state_dbg = 0; retired_cnt = 0; no reg_write.
- CNT_W = 2, 5 back-to-back ADDs -> retired_cnt sequence 1, 2, 3, 0, 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM controller for the 8-bit 4-register CPU; optional single-step mode under SINGLE_STEP_EN.
// Latency: BEQ 3, ADD 4, SW 4, LW 5 cycles at zero memory wait; every memory wait cycle adds one.
// Backpressure: FETCH and MEM hold while mem_ready is low; mem_ready is ignored in all other states.
module multicycle_control_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
`ifdef SINGLE_STEP_EN
   input  logic             step,
`endif
   input  logic [1:0]       op,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_read,
   output logic             mem_write,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             pc_src,
   output logic             alu_src_imm,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             retire,
   output logic [CNT_W-1:0] retired_cnt,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB_R   = 3'd5,
      S_WB_M   = 3'd6
   } state_e;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_LW  = 2'b01;
   localparam logic [1:0] OP_SW  = 2'b10;

   // In single-step mode a finished instruction parks in IDLE until the next step.
`ifdef SINGLE_STEP_EN
   localparam state_e RET_NEXT = S_IDLE;
`else
   localparam state_e RET_NEXT = S_FETCH;
`endif

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // State register and retired-instruction counter; reset abandons any access in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and control decode from state, op, mem_ready and zero.
   always_comb begin
      state_d     = state_q;
      mem_req     = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      alu_src_imm = 1'b0;
      alu_op      = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      retire      = 1'b0;
      case (state_q)
         S_IDLE: begin
`ifdef SINGLE_STEP_EN
            state_d = step ? S_FETCH : S_IDLE;
`else
            state_d = S_FETCH;
`endif
         end
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (op)
               OP_ADD: state_d = S_WB_R;
               OP_LW, OP_SW: begin
                  alu_src_imm = 1'b1;
                  state_d     = S_MEM;
               end
               default: begin
                  // BEQ: subtract for the compare, take the branch target on zero.
                  alu_op   = 2'b01;
                  pc_write = zero;
                  pc_src   = zero;
                  retire   = 1'b1;
                  state_d  = RET_NEXT;
               end
            endcase
         end
         S_MEM: begin
            mem_req   = 1'b1;
            iord      = 1'b1;
            mem_read  = (op == OP_LW);
            mem_write = (op == OP_SW);
            if (mem_ready) begin
               if (op == OP_LW) begin
                  state_d = S_WB_M;
               end else begin
                  retire  = 1'b1;
                  state_d = RET_NEXT;
               end
            end
         end
         S_WB_R: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            retire    = 1'b1;
            state_d   = RET_NEXT;
         end
         S_WB_M: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            retire     = 1'b1;
            state_d    = RET_NEXT;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Counter advances on every retiring edge and wraps naturally.
   always_comb begin
      cnt_d = cnt_q;
      if (retire) cnt_d = cnt_q + CNT_W'(1);
   end

   assign retired_cnt = cnt_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed scoreboard bench for multicycle_control_unit (default build, no single-step).
// Two instances share stimulus: CNT_W=16 and CNT_W=2 for counter wrap.
// Expected per-cycle control words are queued by stimulus and checked by a monitor at negedge.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic [2:0]  st;
      logic [13:0] ctl;
      logic [15:0] cnt;
      logic [1:0]  cnt2;
   } exp_t;

   // ctl bit order: mem_req mem_read mem_write iord ir_write pc_write pc_src
   //                alu_src_imm alu_op[1:0] reg_write reg_dst mem_to_reg retire
   localparam logic [13:0] C_ZERO   = 14'b00000000000000;
   localparam logic [13:0] C_F_RDY  = 14'b11001100000000;
   localparam logic [13:0] C_F_WAIT = 14'b11000000000000;
   localparam logic [13:0] C_EX_MEM = 14'b00000001000000;
   localparam logic [13:0] C_BEQ_T  = 14'b00000110010001;
   localparam logic [13:0] C_BEQ_N  = 14'b00000000010001;
   localparam logic [13:0] C_MEM_LW = 14'b11010000000000;
   localparam logic [13:0] C_SW_RDY = 14'b10110000000001;
   localparam logic [13:0] C_SW_W   = 14'b10110000000000;
   localparam logic [13:0] C_WB_R   = 14'b00000000001101;
   localparam logic [13:0] C_WB_M   = 14'b00000000001011;

   logic clk = 1'b0;
   logic reset;
   logic [1:0] op;
   logic zero, mem_ready;

   logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_imm;
   logic [1:0] alu_op;
   logic reg_write, reg_dst, mem_to_reg, retire;
   logic [15:0] retired_cnt;
   logic [2:0] state_dbg;

   logic b_mem_req, b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_src, b_alu_src_imm;
   logic [1:0] b_alu_op;
   logic b_reg_write, b_reg_dst, b_mem_to_reg, b_retire;
   logic [1:0] b_retired_cnt;
   logic [2:0] b_state_dbg;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_cyc = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.CNT_W(16)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_imm(alu_src_imm),
      .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .retire(retire), .retired_cnt(retired_cnt), .state_dbg(state_dbg)
   );

   multicycle_control_unit #(.CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
      .mem_req(b_mem_req), .mem_read(b_mem_read), .mem_write(b_mem_write), .iord(b_iord),
      .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src), .alu_src_imm(b_alu_src_imm),
      .alu_op(b_alu_op), .reg_write(b_reg_write), .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg),
      .retire(b_retire), .retired_cnt(b_retired_cnt), .state_dbg(b_state_dbg)
   );

   // One cycle of stimulus plus the hand-computed response expected in that cycle.
   task automatic cyc(input logic rst_v, input logic [1:0] op_v, input logic z_v, input logic rdy_v,
                      input logic [2:0] st, input logic [13:0] ctl,
                      input logic [15:0] c, input logic [1:0] c2);
      exp_t e;
      @(posedge clk);
      #1;
      reset     = rst_v;
      op        = op_v;
      zero      = z_v;
      mem_ready = rdy_v;
      e.st   = st;
      e.ctl  = ctl;
      e.cnt  = c;
      e.cnt2 = c2;
      exp_q.push_back(e);
   endtask

   // ADD with zero memory wait: FETCH, DECODE, EXEC, WB_R.
   task automatic add_instr(input logic [15:0] c, input logic [1:0] c2);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 3'd1, C_F_RDY, c, c2);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 3'd2, C_ZERO,  c, c2);
      cyc(1'b0, 2'b00, 1'b1, 1'b1, 3'd3, C_ZERO,  c, c2);
      cyc(1'b0, 2'b00, 1'b0, 1'b0, 3'd5, C_WB_R,  c, c2);
   endtask

   // Monitor: every cycle the DUT presents a control word; pop and compare.
   initial begin
      exp_t e, a, b;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cyc++;
            a.st   = state_dbg;
            a.ctl  = {mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_src,
                      alu_src_imm, alu_op, reg_write, reg_dst, mem_to_reg, retire};
            a.cnt  = retired_cnt;
            a.cnt2 = b_retired_cnt;
            b.st   = b_state_dbg;
            b.ctl  = {b_mem_req, b_mem_read, b_mem_write, b_iord, b_ir_write, b_pc_write, b_pc_src,
                      b_alu_src_imm, b_alu_op, b_reg_write, b_reg_dst, b_mem_to_reg, b_retire};
            n_cmp++;
            if (a !== e) begin
               n_bad++;
               $display("FAIL cyc%0d: got st=%0d ctl=%b cnt=%0d cnt2=%0d, expected st=%0d ctl=%b cnt=%0d cnt2=%0d",
                        n_cyc, a.st, a.ctl, a.cnt, a.cnt2, e.st, e.ctl, e.cnt, e.cnt2);
            end
            n_cmp++;
            if ({b.st, b.ctl} !== {e.st, e.ctl}) begin
               n_bad++;
               $display("FAIL cyc%0d_w2: got st=%0d ctl=%b, expected st=%0d ctl=%b",
                        n_cyc, b.st, b.ctl, e.st, e.ctl);
            end
            n_cmp++;
            if ((mem_read && mem_write) || (!mem_req && (mem_read || mem_write))) begin
               n_bad++;
               $display("FAIL cyc%0d_rw_inv: got req=%b rd=%b wr=%b, expected exclusive rd/wr under req",
                        n_cyc, mem_req, mem_read, mem_write);
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      reset = 1'b1; op = 2'b00; zero = 1'b0; mem_ready = 1'b1;
      // Reset held, then released: IDLE one cycle, then FETCH.
      cyc(1'b1, 2'b00, 1'b0, 1'b1, 3'd0, C_ZERO, 16'd0, 2'd0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 3'd0, C_ZERO, 16'd0, 2'd0);
      // ADD.
      add_instr(16'd0, 2'd0);
      // LW with three wait cycles in MEM: 8 cycles total.
      cyc(1'b0, 2'b01, 1'b0, 1'b1, 3'd1, C_F_RDY,  16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b1, 3'd2, C_ZERO,   16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b1, 3'd3, C_EX_MEM, 16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b0, 3'd4, C_MEM_LW, 16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b0, 3'd4, C_MEM_LW, 16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b0, 3'd4, C_MEM_LW, 16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b1, 3'd4, C_MEM_LW, 16'd1, 2'd1);
      cyc(1'b0, 2'b01, 1'b0, 1'b1, 3'd6, C_WB_M,   16'd1, 2'd1);
      // BEQ taken, with one fetch wait cycle.
      cyc(1'b0, 2'b11, 1'b1, 1'b0, 3'd1, C_F_WAIT, 16'd2, 2'd2);
      cyc(1'b0, 2'b11, 1'b1, 1'b1, 3'd1, C_F_RDY,  16'd2, 2'd2);
      cyc(1'b0, 2'b11, 1'b1, 1'b1, 3'd2, C_ZERO,   16'd2, 2'd2);
      cyc(1'b0, 2'b11, 1'b1, 1'b0, 3'd3, C_BEQ_T,  16'd2, 2'd2);
      // BEQ not taken.
      cyc(1'b0, 2'b11, 1'b0, 1'b1, 3'd1, C_F_RDY,  16'd3, 2'd3);
      cyc(1'b0, 2'b11, 1'b0, 1'b1, 3'd2, C_ZERO,   16'd3, 2'd3);
      cyc(1'b0, 2'b11, 1'b0, 1'b1, 3'd3, C_BEQ_N,  16'd3, 2'd3);
      // SW, one completed store.
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd1, C_F_RDY,  16'd4, 2'd0);
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd2, C_ZERO,   16'd4, 2'd0);
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd3, C_EX_MEM, 16'd4, 2'd0);
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd4, C_SW_RDY, 16'd4, 2'd0);
      // SW stalled in MEM, then reset mid-access: request drops in that cycle.
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd1, C_F_RDY,  16'd5, 2'd1);
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd2, C_ZERO,   16'd5, 2'd1);
      cyc(1'b0, 2'b10, 1'b0, 1'b1, 3'd3, C_EX_MEM, 16'd5, 2'd1);
      cyc(1'b0, 2'b10, 1'b0, 1'b0, 3'd4, C_SW_W,   16'd5, 2'd1);
      cyc(1'b1, 2'b10, 1'b0, 1'b0, 3'd0, C_ZERO,   16'd0, 2'd0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 3'd0, C_ZERO,   16'd0, 2'd0);
      // Five back-to-back ADDs: 2-bit counter runs 1,2,3,0,1.
      add_instr(16'd0, 2'd0);
      add_instr(16'd1, 2'd1);
      add_instr(16'd2, 2'd2);
      add_instr(16'd3, 2'd3);
      add_instr(16'd4, 2'd0);
      cyc(1'b0, 2'b00, 1'b0, 1'b1, 3'd1, C_F_RDY,  16'd5, 2'd1);
      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL timeout: got no completion, expected finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
